// File: rtl/conv_mask_mac_p_if.sv
// Sample/result bus for conv_mask_mac_p.
//
// Handshake: the engine is always ready. A (a, b) pair is accepted on every
// rising clk edge where act=1; there is no back-pressure. result_valid is a
// one-cycle strobe with no ready; result keeps its value between strobes.
// c_i reports the tap slot the next accepted pair will fill.
//
// The master drives samples (the producer); the slave is the engine.
interface conv_mask_mac_p_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 21,
  parameter int IDX_W  = 4
);
  logic              act;
  logic [DATA_W-1:0] a;
  logic [COEF_W-1:0] b;
  logic [ACC_W-1:0]  result;
  logic              result_valid;
  logic [IDX_W-1:0]  c_i;

  // Sample producer side
  modport master (
    output act,
    output a,
    output b,
    input  result,
    input  result_valid,
    input  c_i
  );

  // Engine side
  modport slave (
    input  act,
    input  a,
    input  b,
    output result,
    output result_valid,
    output c_i
  );
endinterface

// File: rtl/conv_mask_mac_p.sv
// conv_mask_mac_p: streaming multiply-accumulate for convolution masks.
//
// One (pixel, coefficient) pair per active cycle; TAPS products form one
// window sum, emitted (arithmetically shifted by SHIFT) with a single-cycle
// valid strobe two edges after the last tap is accepted.
//
// Build option: define CONV_MASK_SAT_EN to clamp the shifted sum to the
// pixel range [0, 2^DATA_W-1]. Without it the raw signed sum is emitted.
//
// Pipeline:
//   stage 1 (acceptance edge): product, first-tap and last-tap flags
//   stage 2 (next edge)      : accumulate; on last tap, load result + strobe
// Requirements on parameters: 2^IDX_W >= TAPS, ACC_W > DATA_W and
// ACC_W >= DATA_W+COEF_W+1 (product fits the accumulator).
module conv_mask_mac_p #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 9,
  parameter int IDX_W  = 4,
  parameter int ACC_W  = 21,
  parameter int SHIFT  = 0
) (
  input  logic                clk,
  input  logic                rst,
  conv_mask_mac_p_if.slave    bus
);

  localparam int PROD_W = DATA_W + COEF_W + 1;

  // Last tap index in counter width, used for wrap and last-flag detection.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  // ---------------------------------------------------------------------
  // Product formation
  // ---------------------------------------------------------------------
  // The pixel is unsigned: prepend a zero so it can join a signed multiply
  // without being misread as negative.
  logic signed [DATA_W:0]   a_ext;
  logic signed [COEF_W-1:0] b_sgn;
  logic signed [PROD_W-1:0] prod_w;
  logic signed [ACC_W-1:0]  prod_ext;

  assign a_ext    = {1'b0, bus.a};
  assign b_sgn    = bus.b;
  // Both operands are sign-extended to the full product width first, so
  // the multiply is exact and lint sees matching widths.
  assign prod_w   = PROD_W'(a_ext) * PROD_W'(b_sgn);
  assign prod_ext = ACC_W'(prod_w);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0]        c_i_q;
  logic                    s1_valid;
  logic                    s1_first;
  logic                    s1_last;
  logic signed [ACC_W-1:0] s1_prod;
  logic signed [ACC_W-1:0] acc;
  logic [ACC_W-1:0]        result_q;
  logic                    valid_q;

  // ---------------------------------------------------------------------
  // Accumulate and output shaping
  // ---------------------------------------------------------------------
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] shifted;
  logic [ACC_W-1:0]        shaped;

  // A first-tap product replaces the running sum, so consecutive windows
  // never leak into each other even when they abut without a gap.
  assign acc_next = s1_first ? s1_prod : (acc + s1_prod);
  assign shifted  = acc_next >>> SHIFT;

`ifdef CONV_MASK_SAT_EN
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << DATA_W) - 1);

  // Clamp to the pixel range so the result can feed a pixel path directly.
  always_comb begin
    shaped = shifted;
    if (shifted[ACC_W-1]) begin
      shaped = '0;
    end else if (shifted > PIX_MAX) begin
      shaped = PIX_MAX;
    end
  end
`else
  // Raw signed shifted sum; no clamp hardware in this build.
  always_comb begin
    shaped = shifted;
  end
`endif

  // ---------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------

  // Tap counter: advances per accepted sample, wraps at TAPS-1, holds in gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_i_q <= '0;
    end else if (bus.act) begin
      if (c_i_q == LAST_IDX) begin
        c_i_q <= '0;
      end else begin
        c_i_q <= c_i_q + IDX_W'(1);
      end
    end
  end

  // Stage 1: capture the product and its position within the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else begin
      s1_valid <= bus.act;
      if (bus.act) begin
        s1_first <= (c_i_q == '0);
        s1_last  <= (c_i_q == LAST_IDX);
        s1_prod  <= prod_ext;
      end
    end
  end

  // Stage 2: accumulate; the last tap publishes the window and strobes valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= s1_valid && s1_last;
      if (s1_valid) begin
        acc <= acc_next;
        if (s1_last) begin
          result_q <= shaped;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.c_i          = c_i_q;
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;

endmodule

// File: tb/tb_conv_mask_mac_p.sv
// Testbench for conv_mask_mac_p: directed windows, expected results queued
// by the stimulus side and checked by an independent monitor on result_valid.
// Builds with or without CONV_MASK_SAT_EN (SHIFT=4 in the clamped build).
module tb_conv_mask_mac_p;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 9;
  localparam int IDX_W  = 4;
  localparam int ACC_W  = 21;
`ifdef CONV_MASK_SAT_EN
  localparam bit SAT   = 1'b1;
  localparam int SHIFT = 4;
`else
  localparam bit SAT   = 1'b0;
  localparam int SHIFT = 0;
`endif

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_mask_mac_p_if #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W), .IDX_W(IDX_W)
  ) bus_if ();

  conv_mask_mac_p #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS),
    .IDX_W(IDX_W), .ACC_W(ACC_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  // ---------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------
  logic [ACC_W-1:0] exp_q[$];
  logic [ACC_W-1:0] held_result = '0;
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_valid_cyc = -1;
  int last_gap = 0;

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act_v, act_v, exp_v, exp_v);
    end
  endtask

  // Pick the hand-computed expectation for the active build.
  function automatic logic [ACC_W-1:0] pick(input int raw_v, input int sat_v);
    return SAT ? ACC_W'(sat_v) : ACC_W'(raw_v);
  endfunction

  // ---------------------------------------------------------------------
  // Monitor: pops on each strobe, checks result holds between strobes
  // ---------------------------------------------------------------------
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      held_result = '0;
    end else if (bus_if.result_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid: got result %0d with no expectation pending", bus_if.result);
      end else begin
        held_result = exp_q.pop_front();
        check("window_result", 32'(bus_if.result), 32'(held_result));
      end
      if (last_valid_cyc >= 0) last_gap = cyc - last_valid_cyc;
      last_valid_cyc = cyc;
    end else begin
      check("result_hold", 32'(bus_if.result), 32'(held_result));
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks (called at posedge+1, return at posedge+1)
  // ---------------------------------------------------------------------
  task automatic drive_sample(input int av, input int bv);
    bus_if.act = 1'b1;
    bus_if.a   = DATA_W'(av);
    bus_if.b   = COEF_W'(bv);
    @(posedge clk);
    #1;
    bus_if.act = 1'b0;
  endtask

  task automatic idle(input int n);
    bus_if.act = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic window(input int av, input int bv);
    for (int i = 0; i < TAPS; i++) drive_sample(av, bv);
  endtask

  // Wait for the monitor to consume every expectation, bounded.
  task automatic drain(input string name);
    int budget;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: %0d results still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    idle(2);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    bus_if.act = 1'b0;
    bus_if.a   = '0;
    bus_if.b   = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("reset_result", 32'(bus_if.result), 32'd0);
    check("reset_valid", 32'(bus_if.result_valid), 32'd0);
    check("reset_c_i", 32'(bus_if.c_i), 32'd0);
    idle(1);

    // Full window of 255*50: 9*12750 = 114750
    exp_q.push_back(pick(114750, 255));
    window(255, 50);
    drain("basic");
    check("c_i_after_window", 32'(bus_if.c_i), 32'd0);

    // Back-to-back windows: 114750 then 9*2100 = 18900 (1181 clamps to 255)
    exp_q.push_back(pick(114750, 255));
    exp_q.push_back(pick(18900, 255));
    window(255, 50);
    window(30, 70);
    drain("back_to_back");
    check("b2b_valid_spacing", 32'(last_gap), 32'(TAPS));

    // Signed coefficient: 9*-255 = -2295 = 0x1FF709 in 21 bits
    exp_q.push_back(pick(-2295, 0));
    window(255, -1);
    drain("negative");

    // Small window: 9*16 = 144, 144>>>4 = 9
    exp_q.push_back(pick(144, 9));
    window(16, 1);
    drain("small");

    // Extremes: 9*255*-128 = -293760 ; 9*255*127 = 291465 (>>4 = 18216)
    exp_q.push_back(pick(-293760, 0));
    window(255, -128);
    exp_q.push_back(pick(291465, 255));
    window(255, 127);
    drain("extremes");

    // Gapped window: 3 idle cycles after taps 2 and 6, c_i must hold
    exp_q.push_back(pick(114750, 255));
    for (int i = 0; i < TAPS; i++) begin
      drive_sample(255, 50);
      if (i == 2 || i == 6) begin
        for (int g = 0; g < 3; g++) begin
          check("gap_c_i_hold", 32'(bus_if.c_i), 32'(i + 1));
          idle(1);
        end
      end
    end
    drain("gapped");

    // Reset mid-window: partial 5 taps discarded, then a clean 30*70 window
    for (int i = 0; i < 5; i++) drive_sample(255, 50);
    check("mid_c_i_before_rst", 32'(bus_if.c_i), 32'd5);
    rst = 1'b1;
    bus_if.act = 1'b1;          // reset wins; this sample is dropped
    bus_if.a = 8'd255;
    bus_if.b = 8'd50;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_if.act = 1'b0;
    check("mid_c_i_after_rst", 32'(bus_if.c_i), 32'd0);
    exp_q.push_back(pick(18900, 255));
    window(30, 70);
    drain("mid_reset");
    check("c_i_final", 32'(bus_if.c_i), 32'd0);

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute runtime bound
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/conv_mask_mac_p.md
Name: conv_mask_mac_p

Overview:
Parametrised streaming multiply-accumulate engine for the edge-preserving filter's convolution masks. It consumes one (pixel, coefficient) pair per active cycle and accumulates TAPS products into one window sum. It then emits a normalised result with a one-cycle valid strobe. It generalises the fixed 8x8-bit conv_mask by adding:
- configurable widths and tap count
- signed coefficients
- window framing
- an optional output clamp

Parameters:
DATA_W, 8, pixel width (unsigned)
COEF_W, 8, coefficient width (two's complement)
TAPS, 9, products per window (2..256)
IDX_W, 4, tap counter width; must satisfy 2^IDX_W >= TAPS
ACC_W, 21, accumulator/result width (signed); default = DATA_W+COEF_W+1+ceil(log2 TAPS)
SHIFT, 0, arithmetic right shift applied to the final sum (0..ACC_W-1)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
act  in  1  sample valid; pair accepted on every edge where act=1 (always ready)
a  in  DATA_W  pixel, unsigned
b  in  COEF_W  coefficient, signed
result  out  ACC_W  signed window sum >>> SHIFT (clamped form if the optional feature is enabled)
result_valid  out  1  single-cycle strobe marking a new result
c_i  out  IDX_W  tap index the next accepted sample will occupy (0..TAPS-1)

Behaviour:
- Reset (rst=1 at an edge): c_i=0, result=0, result_valid=0; accumulator, product register and pipeline flags cleared. No output pending from a partial window.
- Product formation: a is zero-extended to DATA_W+1 and multiplied signed by b, giving a DATA_W+COEF_W+1-bit product. It is sign-extended to ACC_W.
- Tap counter: increments on each accepted sample; wraps TAPS-1 -> 0. It holds when act=0, so gaps of any length inside a window are legal.
- Stage 1 (edge t, act=1): register the product, first flag (c_i==0) and last flag (c_i==TAPS-1). If act=0, stage-1 valid=0.
- Stage 2 (edge t+1, stage-1 valid):
  - first: acc <= prod
  - otherwise: acc <= acc + prod
  - last: result <= (acc_next) >>> SHIFT, result_valid <= 1
- Latency: result_valid asserts for the cycle following edge t+1, where t is the acceptance edge of tap TAPS-1. It is high for exactly one cycle, then low.
- result holds its value until the next window completes.
- Back-to-back windows with no bubble are supported. The first-flag load replaces the sum, so there is no carry-over between windows.
- Overflow: wraps modulo 2^ACC_W. There is no detection; sizing ACC_W per the default formula guarantees no overflow.
- Reset mid-window discards all partial state; the next accepted sample is tap 0.
- rst and act asserted together: reset wins; the sample is dropped.

Optional Feature:
Macro CONV_MASK_SAT_EN.
- Defined: the shifted sum is clamped to [0, 2^DATA_W-1] and zero-extended onto result. Negative sums give 0; sums above 2^DATA_W-1 give 2^DATA_W-1. This makes result directly usable as a pixel.
- Undefined: result is the raw signed shifted sum, with no clamp logic synthesised.
- Latency is identical in both builds.

Test Plan:
- Default params, no macro. rst for 1 cycle, then 9 consecutive cycles of a=255, b=50 -> one result_valid pulse 2 edges after the 9th sample, result=114750, c_i back to 0.
- Back-to-back windows. 9x (a=255, b=50) followed immediately by 9x (a=30, b=70) -> results 114750 then 18900, with valid pulses exactly 9 cycles apart.
- Signed coefficients. 9x (a=255, b=-1) -> result = -2295 (0x1FF709 in 21 bits).
- Gapped input. Same 9x (255, 50) samples with act=0 for 3 cycles after taps 2 and 6 -> result=114750; c_i holds during gaps; no spurious valid.
- Reset mid-window. 5 samples (255, 50), rst for 1 cycle, then 9 samples (30, 70) -> only one valid pulse, result=18900.
- CONV_MASK_SAT_EN, SHIFT=4:
  - 9x (255, 50) -> 114750>>>4 = 7171 clamps to result=255
  - 9x (255, -1) -> result=0
  - 9x (16, 1) -> 144>>>4 = 9, result=9
